// File: rtl/const_pkg.sv
// Shared flag constants so polarity intent reads the same across the system bus blocks.
package const_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic HIGH  = 1'b1;
    localparam logic LOW   = 1'b0;
    localparam logic VAL   = 1'b1;
    localparam logic INV   = 1'b0;

endpackage

// File: rtl/wb_scratch_resp_pkg.sv
// Types and helpers for the Wishbone scratch-memory responder.
package wb_scratch_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        HOLD
    } state_t;

    localparam int WS_W = 3;

    // True when the address falls in the naturally aligned window starting at base.
    function automatic logic in_window(input logic [31:0] adr,
                                       input logic [31:0] base,
                                       input int unsigned span_w);
        return (adr >> span_w) == (base >> span_w);
    endfunction

endpackage

// File: rtl/wb_scratch_ram.sv
// Single-port synchronous RAM with byte-lane write enables; contents are never reset.
module wb_scratch_ram #(
    parameter int unsigned DWIDTH = 64,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DWIDTH/8-1:0]      sel,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DWIDTH-1:0]        wdata,
    output logic [DWIDTH-1:0]        rdata
);

    localparam int BYTES = int'(DWIDTH / 8);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (sel[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_scratch_resp.sv
// Wishbone B4 classic-cycle responder in front of a scratch RAM: window decode,
// programmable wait states, byte-lane writes, ACK for hits and ERR for misses.
module wb_scratch_resp
    import const_pkg::*, wb_scratch_resp_pkg::*;
#(
    parameter int unsigned DWIDTH      = 64,
    parameter int unsigned DEPTH       = 256,
    parameter logic [31:0] BASE        = 32'hFFFC0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic [DWIDTH/8-1:0] sel_i,
    input  logic [31:0]         adr_i,
    input  logic [DWIDTH-1:0]   dat_i,
    output logic                ack_o,
    output logic                err_o,
    output logic [DWIDTH-1:0]   dat_o
);

    localparam int unsigned BYTES  = DWIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(BYTES);
    localparam int unsigned SPAN_W = $clog2(DEPTH * BYTES);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam logic [WS_W-1:0] WS_LOAD = (WAIT_STATES > 0) ? WS_W'(WAIT_STATES - 1) : '0;

    state_t            state;
    logic [WS_W-1:0]   wait_cnt;
    logic              lat_we;
    logic              lat_hit;
    logic [BYTES-1:0]  lat_sel;
    logic [DWIDTH-1:0] lat_dat;
    logic [IDX_W-1:0]  lat_idx;
    logic              rd_ack;

    logic              req;
    logic              cur_we;
    logic              cur_hit;
    logic [BYTES-1:0]  cur_sel;
    logic [DWIDTH-1:0] cur_dat;
    logic [IDX_W-1:0]  cur_idx;
    logic              go_resp;
    logic              ram_we;
    logic [DWIDTH-1:0] ram_q;

    // In IDLE the live bus fields feed the RAM so a zero-wait access still lands on RESP entry.
    always_comb begin
        req = cyc_i & stb_i;
        if (state == IDLE) begin
            cur_we  = we_i;
            cur_hit = in_window(adr_i, BASE, SPAN_W) ? VAL : INV;
            cur_sel = sel_i;
            cur_dat = dat_i;
            cur_idx = adr_i[SPAN_W-1:OFF_W];
        end else begin
            cur_we  = lat_we;
            cur_hit = lat_hit;
            cur_sel = lat_sel;
            cur_dat = lat_dat;
            cur_idx = lat_idx;
        end

        go_resp = FALSE;
        unique case (state)
            IDLE:    go_resp = (req == TRUE) && (WAIT_STATES == 0);
            WAIT:    go_resp = (cyc_i == TRUE) && (wait_cnt == '0);
            default: go_resp = FALSE;
        endcase

        ram_we = go_resp & cur_we & (cur_hit == VAL) & rst_ni;
    end

    wb_scratch_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk_i),
        .we    (ram_we),
        .sel   (cur_sel),
        .addr  (cur_idx),
        .wdata (cur_dat),
        .rdata (ram_q)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            wait_cnt <= '0;
            ack_o    <= LOW;
            err_o    <= LOW;
            rd_ack   <= LOW;
            lat_we   <= LOW;
            lat_hit  <= INV;
            lat_sel  <= '0;
            lat_dat  <= '0;
            lat_idx  <= '0;
        end else begin
            ack_o  <= LOW;
            err_o  <= LOW;
            rd_ack <= LOW;
            if (go_resp) begin
                ack_o  <= cur_hit;
                err_o  <= ~cur_hit;
                rd_ack <= cur_hit & ~cur_we;
            end

            unique case (state)
                IDLE: begin
                    if (req) begin
                        lat_we   <= cur_we;
                        lat_hit  <= cur_hit;
                        lat_sel  <= cur_sel;
                        lat_dat  <= cur_dat;
                        lat_idx  <= cur_idx;
                        wait_cnt <= WS_LOAD;
                        state    <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cyc_i == LOW) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == '0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - WS_W'(1);
                    end
                end
                RESP: state <= HOLD;
                // A strobe still held from the finished transfer must not start another one.
                HOLD: begin
                    if (stb_i == LOW || cyc_i == LOW) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dat_o = rd_ack ? ram_q : '0;

endmodule
